// File: rtl/alu_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_muldiv_ctrl
//  Purpose  : ALU control decode for the MIPS datapath plus an iterative
//             multiply/divide engine owning the HI/LO registers.
//             Handles mult, multu, div, divu (WIDTH iterations + 1 fix-up
//             cycle), mthi/mtlo (single edge) and mfhi/mflo (read only).
//  Ports    : CLK, RST (async, active-low)
//             Valid, ALUOP[1:0], Funct[5:0], SrcA, SrcB  - instruction in
//             ALUControl[3:0]                            - ALU select (comb)
//             Busy                                       - engine running
//             Stall                                      - hold instruction
//             HiLoRead, HiLoOut                          - mfhi/mflo result
//             HI, LO                                     - architectural regs
//  Revision : 1.0  initial release
// ============================================================================
module alu_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Valid,
    input  logic [1:0]       ALUOP,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [3:0]       ALUControl,
    output logic             Busy,
    output logic             Stall,
    output logic             HiLoRead,
    output logic [WIDTH-1:0] HiLoOut,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [5:0] c_F_MFHI = 6'b010000;
    localparam logic [5:0] c_F_MTHI = 6'b010001;
    localparam logic [5:0] c_F_MFLO = 6'b010010;
    localparam logic [5:0] c_F_MTLO = 6'b010011;
    localparam int         c_CNT_W  = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIN  = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH:0]     r_acc_hi;   // partial product high / partial remainder
    logic [WIDTH-1:0]   r_acc_lo;   // multiplier bits / dividend-then-quotient
    logic [WIDTH-1:0]   r_opb;      // |multiplicand| or |divisor|
    logic               r_neg_q;    // negate product / quotient at fix-up
    logic               r_neg_r;    // negate remainder (dividend sign)
    logic               r_dz;       // divide by zero
    logic               r_is_div;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic w_rtype, w_hilo, w_accept, w_is_mul, w_is_div, w_signed;

    assign w_rtype  = (ALUOP == 2'b10);
    assign w_hilo   = w_rtype & ((Funct[5:2] == 4'b0100) | (Funct[5:2] == 4'b0110));
    assign w_accept = Valid & w_hilo & ~Busy;
    assign w_is_mul = (Funct[5:1] == 5'b01100);
    assign w_is_div = (Funct[5:1] == 5'b01101);
    assign w_signed = ~Funct[0];

    always_comb begin
        ALUControl = 4'b0000;
        if (ALUOP == 2'b00) begin
            ALUControl = 4'b0010;
        end else if (ALUOP[0]) begin
            ALUControl = 4'b0110;
        end else begin
            case (Funct)
                6'b100000: ALUControl = 4'b0010;
                6'b100010: ALUControl = 4'b0110;
                6'b100100: ALUControl = 4'b0000;
                6'b100101: ALUControl = 4'b0001;
                6'b100111: ALUControl = 4'b1100;
                6'b101010: ALUControl = 4'b0111;
                default:   ALUControl = 4'b0000;
            endcase
        end
    end

    assign Busy     = (r_state != S_IDLE);
    assign Stall    = Busy & Valid & w_hilo;
    assign HiLoRead = Valid & w_rtype & ((Funct == c_F_MFHI) | (Funct == c_F_MFLO)) & ~Stall;
    assign HiLoOut  = (Funct == c_F_MFHI) ? r_hi : r_lo;
    assign HI       = r_hi;
    assign LO       = r_lo;

    // ------------------------------------------------------------------
    // Datapath step / fix-up values
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift, w_div_trial;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

    assign w_abs_a = (w_signed & SrcA[WIDTH-1]) ? -SrcA : SrcA;
    assign w_abs_b = (w_signed & SrcB[WIDTH-1]) ? -SrcB : SrcB;

    // Shift-add: add multiplicand when the current multiplier LSB is set,
    // then shift the {acc_hi, acc_lo} pair right by one.
    assign w_mul_sum = r_acc_hi + (r_acc_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});

    // Restoring divide: bring in the next dividend bit, try the subtract.
    assign w_div_shift = {r_acc_hi[WIDTH-1:0], r_acc_lo[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_opb};

    assign w_prod     = {r_acc_hi[WIDTH-1:0], r_acc_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    // Divide by zero leaves the magnitude remainder equal to |dividend|, so
    // the ordinary remainder sign fix already yields SrcA; only LO is forced.
    assign w_quo_fix  = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? -r_acc_lo : r_acc_lo);
    assign w_rem_fix  = r_neg_r ? -r_acc_hi[WIDTH-1:0] : r_acc_hi[WIDTH-1:0];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept & w_is_mul)      w_next = S_MUL;
                else if (w_accept & w_is_div) w_next = S_DIV;
            end
            S_MUL:   if (r_count == '0) w_next = S_FIN;
            S_DIV:   if (r_count == '0) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opb    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept & (w_is_mul | w_is_div)) begin
                        r_count  <= c_CNT_INIT;
                        r_acc_hi <= '0;
                        r_acc_lo <= w_abs_a;
                        r_opb    <= w_abs_b;
                        r_is_div <= w_is_div;
                        r_dz     <= w_is_div & (SrcB == '0);
                        r_neg_q  <= w_signed & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                        r_neg_r  <= w_signed & SrcA[WIDTH-1];
                    end
                    if (w_accept & (Funct == c_F_MTHI)) r_hi <= SrcA;
                    if (w_accept & (Funct == c_F_MTLO)) r_lo <= SrcA;
                end
                S_MUL: begin
                    r_acc_hi <= {1'b0, w_mul_sum[WIDTH:1]};
                    r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                    if (r_count != '0) r_count <= r_count - c_CNT_ONE;
                end
                S_DIV: begin
                    if (!w_div_trial[WIDTH]) begin
                        r_acc_hi <= {1'b0, w_div_trial[WIDTH-1:0]};
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_acc_hi <= {1'b0, w_div_shift[WIDTH-1:0]};
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
                    end
                    if (r_count != '0) r_count <= r_count - c_CNT_ONE;
                end
                S_FIN: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_muldiv_ctrl
//  Purpose  : Self-checking bench for alu_muldiv_ctrl: decode vector table,
//             scoreboarded multiply/divide operations, stall, mthi/mflo/mfhi
//             and mid-operation reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_muldiv_ctrl;

    localparam int W = 32;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic         CLK = 1'b0;
    logic         RST;
    logic         Valid;
    logic [1:0]   ALUOP;
    logic [5:0]   Funct;
    logic [W-1:0] SrcA, SrcB;
    logic [3:0]   ALUControl;
    logic         Busy, Stall, HiLoRead;
    logic [W-1:0] HiLoOut, HI, LO;

    alu_muldiv_ctrl #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .Valid(Valid), .ALUOP(ALUOP), .Funct(Funct),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .Busy(Busy),
        .Stall(Stall), .HiLoRead(HiLoRead), .HiLoOut(HiLoOut), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] aluop;
        logic [5:0] funct;
        logic [3:0] ctrl;
    } dec_vec_t;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } sb_t;

    sb_t sb_q[$];

    // Reference model built on the simulator's own arithmetic.
    function automatic sb_t model(input string nm, input logic [5:0] f,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
        sb_t r;
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p;
        r.name = nm;
        r.hi = '0;
        r.lo = '0;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (f)
            F_MULT:  begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
            F_MULTU: begin p = ua * ub; r.hi = p[63:32]; r.lo = p[31:0]; end
            F_DIV: begin
                if (b == 0) begin r.lo = '1; r.hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r.lo = a; r.hi = '0; end
                else begin r.lo = $signed(a) / $signed(b); r.hi = $signed(a) % $signed(b); end
            end
            default: begin
                if (b == 0) begin r.lo = '1; r.hi = a; end
                else begin r.lo = a / b; r.hi = a % b; end
            end
        endcase
        return r;
    endfunction

    // Issue one mul/div, scramble operands while busy, compare on completion.
    task automatic run_op(input string nm, input logic [5:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        int cycles;
        sb_t e;
        sb_q.push_back(model(nm, f, a, b));
        @(negedge CLK);
        Valid = 1'b1; ALUOP = 2'b10; Funct = f; SrcA = a; SrcB = b;
        @(negedge CLK);
        Valid = 1'b0; SrcA = $urandom; SrcB = $urandom;
        #1 chk({nm, "_stall_valid_low"}, Stall, 0);
        cycles = 0;
        while (Busy && cycles < 200) begin
            cycles++;
            @(negedge CLK);
            SrcA = $urandom; SrcB = $urandom;
        end
        chk({nm, "_busy_cycles"}, cycles, W + 1);
        e = sb_q.pop_front();
        chk({e.name, "_HI"}, HI, e.hi);
        chk({e.name, "_LO"}, LO, e.lo);
    endtask

    initial begin
        dec_vec_t dec_tab[12];
        sb_t      e;
        int       k, stall_bad;
        logic [W-1:0] lo_prev;
        logic [5:0] fsel[4];

        dec_tab[0]  = '{2'b00, 6'b000000, 4'b0010};
        dec_tab[1]  = '{2'b01, 6'b100100, 4'b0110};
        dec_tab[2]  = '{2'b11, 6'b100000, 4'b0110};
        dec_tab[3]  = '{2'b10, 6'b100000, 4'b0010};
        dec_tab[4]  = '{2'b10, 6'b100010, 4'b0110};
        dec_tab[5]  = '{2'b10, 6'b100100, 4'b0000};
        dec_tab[6]  = '{2'b10, 6'b100101, 4'b0001};
        dec_tab[7]  = '{2'b10, 6'b100111, 4'b1100};
        dec_tab[8]  = '{2'b10, 6'b101010, 4'b0111};
        dec_tab[9]  = '{2'b10, 6'b000000, 4'b0000};
        dec_tab[10] = '{2'b10, 6'b011000, 4'b0000};
        dec_tab[11] = '{2'b10, 6'b010000, 4'b0000};

        // Reset state, with a mult presented that must not start.
        RST = 1'b0; Valid = 1'b1; ALUOP = 2'b10; Funct = F_MULT; SrcA = 5; SrcB = 6;
        #3;
        chk("rst_busy", Busy, 0);
        chk("rst_stall", Stall, 0);
        chk("rst_HI", HI, 0);
        chk("rst_LO", LO, 0);
        @(negedge CLK);
        chk("rst_hold_busy", Busy, 0);
        Valid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;

        // Decode table.
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            ALUOP = dec_tab[i].aluop; Funct = dec_tab[i].funct;
            #1 chk($sformatf("decode_%0d", i), ALUControl, dec_tab[i].ctrl);
        end

        // Engine operations.
        run_op("mult_neg3x7", F_MULT, 32'hFFFF_FFFD, 32'd7);
        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_neg7_2", F_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_7_0", F_DIVU, 32'd7, 32'd0);
        run_op("div_minneg", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_neg_by0", F_DIV, 32'hFFFF_FFF0, 32'd0);
        fsel[0] = F_MULT; fsel[1] = F_MULTU; fsel[2] = F_DIV; fsel[3] = F_DIVU;
        for (int i = 0; i < 4; i++)
            run_op($sformatf("rand_%0d", i), fsel[i], $urandom,
                   (i >= 2) ? 32'($urandom_range(1, 1000)) : 32'($urandom));

        // mflo held during a mult, with an add slipped in mid-way.
        sb_q.push_back(model("stall_mult", F_MULT, 32'd5, 32'd6));
        @(negedge CLK);
        Valid = 1'b1; ALUOP = 2'b10; Funct = F_MULT; SrcA = 5; SrcB = 6;
        @(negedge CLK);
        k = 0; stall_bad = 0;
        while (Busy && k < 200) begin
            if (k == 5) begin
                ALUOP = 2'b00; Funct = F_ADD;
                #1;
                chk("add_during_busy_stall", Stall, 0);
                chk("add_during_busy_ctrl", ALUControl, 4'b0010);
            end else begin
                ALUOP = 2'b10; Funct = F_MFLO;
                #1;
                if (Stall !== 1'b1) stall_bad++;
            end
            k++;
            @(negedge CLK);
        end
        chk("mflo_stall_cycles_bad", stall_bad, 0);
        chk("mflo_busy_cycles", k, W + 1);
        #1;
        e = sb_q.pop_front();
        chk("mflo_after_stall", Stall, 0);
        chk("mflo_after_read", HiLoRead, 1);
        chk("mflo_after_out", HiLoOut, e.lo);
        chk("stall_mult_HI", HI, e.hi);

        // mthi, then mflo, then mfhi back to back.
        lo_prev = LO;
        @(negedge CLK);
        Funct = F_MTHI; SrcA = 32'h1234;
        #1 chk("mthi_stall", Stall, 0);
        @(negedge CLK);
        chk("mthi_HI", HI, 32'h1234);
        chk("mthi_LO_kept", LO, lo_prev);
        chk("mthi_busy", Busy, 0);
        Funct = F_MFLO;
        #1 chk("mflo_out", HiLoOut, lo_prev);
        chk("mflo_stall", Stall, 0);
        @(negedge CLK);
        Funct = F_MFHI;
        #1 chk("mfhi_out", HiLoOut, 32'h1234);
        chk("mfhi_read", HiLoRead, 1);
        @(negedge CLK);
        Valid = 1'b0;
        chk("mfhi_HI_kept", HI, 32'h1234);
        chk("mfhi_LO_kept", LO, lo_prev);

        // Reset at iteration 10 of a divu.
        @(negedge CLK);
        Valid = 1'b1; ALUOP = 2'b10; Funct = F_DIVU; SrcA = 32'hFFFF_0000; SrcB = 3;
        @(posedge CLK);
        repeat (10) @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("midrst_busy", Busy, 0);
        chk("midrst_HI", HI, 0);
        chk("midrst_LO", LO, 0);
        chk("midrst_stall", Stall, 0);
        ALUOP = 2'b00;
        #1 chk("midrst_ctrl", ALUControl, 4'b0010);
        Valid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        run_op("post_rst_mult", F_MULT, 32'd3, 32'd5);
        chk("post_rst_LO15", LO, 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
